// File: rtl/spi_pkg.sv
// Shared types and constants for the parameterised SPI master: FSM states,
// clock-mode encodings and counter sizing helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TRAIL = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam bit CPOL_IDLE_LOW     = 1'b0;
    localparam bit CPOL_IDLE_HIGH    = 1'b1;
    localparam bit CPHA_SAMPLE_LEAD  = 1'b0;
    localparam bit CPHA_SAMPLE_TRAIL = 1'b1;

    // Width of a counter or index that must reach terminal-1; never below one bit.
    function automatic int spi_cnt_w(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK divider: toggles SCK every CLK_DIV cycles while enabled and flags which
// toggle is a leading or trailing edge; SCK rests at CPOL otherwise.
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter bit CPOL    = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sck_o,
    output logic lead_o,
    output logic trail_o
);

    localparam int DIV_W = spi_cnt_w(CLK_DIV);

    logic [DIV_W-1:0] div_q;
    logic             sck_q;
    logic             tick;

    assign tick = en_i && (div_q == DIV_W'(CLK_DIV - 1));

    // Strobes mark the edge on which SCK is about to change, so the FSM acts
    // on the same clock edge that moves SCK.
    assign lead_o  = tick && (sck_q == CPOL);
    assign trail_o = tick && (sck_q != CPOL);
    assign sck_o   = sck_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            sck_q <= CPOL;
        end else if (!en_i) begin
            div_q <= '0;
            sck_q <= CPOL;
        end else if (tick) begin
            div_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one word per START, MSB first, selectable CPOL/CPHA,
// per-transfer chip select and a programmable CS-high gap between words.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 2,
    parameter bit CPOL    = 1'b0,
    parameter bit CPHA    = 1'b0,
    parameter int CS_GAP  = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [spi_cnt_w(NUM_CS)-1:0] cs_sel_i,
    input  logic [DATA_W-1:0]            data_mosi_i,
    input  logic                         miso_i,
    output logic                         mosi_o,
    output logic                         sck_o,
    output logic [NUM_CS-1:0]            csbar_o,
    output logic                         busy_o,
    output logic                         fin_o,
    output logic [DATA_W-1:0]            data_miso_o
);

    localparam int CS_W   = spi_cnt_w(NUM_CS);
    localparam int BIT_W  = spi_cnt_w(DATA_W);
    localparam int PH_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int PH_W   = spi_cnt_w(PH_MAX);

    spi_state_e        state_q;
    logic [PH_W-1:0]   ph_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic              mosi_q;
    logic [NUM_CS-1:0] csbar_q;
    logic              busy_q;
    logic              fin_q;
    logic [DATA_W-1:0] data_miso_q;

    logic              sel_valid;
    logic              gap_done;
    logic              accept;
    logic              shift_en;
    logic              sck_lead;
    logic              sck_trail;
    logic [NUM_CS-1:0] sel_csbar;

    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_csbar
            assign sel_csbar[gi] = (cs_sel_i != CS_W'(gi));
        end
    endgenerate

    assign sel_valid = ({1'b0, cs_sel_i} < (CS_W + 1)'(NUM_CS));
    assign gap_done  = (state_q == ST_GAP) && (ph_q == PH_W'(CS_GAP - 1));
    // The last GAP cycle counts as idle so a held START restarts with exactly
    // CS_GAP cycles of CS high; BUSY then stays high across the two words.
    assign accept    = start_i && sel_valid && ((state_q == ST_IDLE) || gap_done);
    assign shift_en  = (state_q == ST_SHIFT);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_sck_gen (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .en_i    (shift_en),
        .sck_o   (sck_o),
        .lead_o  (sck_lead),
        .trail_o (sck_trail)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            ph_q        <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            mosi_q      <= 1'b0;
            csbar_q     <= '1;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            data_miso_q <= '0;
        end else begin
            fin_q <= 1'b0;
            if (accept) begin
                state_q <= ST_LEAD;
                ph_q    <= '0;
                bit_q   <= '0;
                rx_q    <= '0;
                csbar_q <= sel_csbar;
                busy_q  <= 1'b1;
                if (CPHA == CPHA_SAMPLE_LEAD) begin
                    mosi_q <= data_mosi_i[DATA_W-1];
                    tx_q   <= {data_mosi_i[DATA_W-2:0], 1'b0};
                end else begin
                    mosi_q <= 1'b0;
                    tx_q   <= data_mosi_i;
                end
            end else begin
                case (state_q)
                    ST_LEAD: begin
                        if (ph_q == PH_W'(CLK_DIV - 1)) begin
                            state_q <= ST_SHIFT;
                            ph_q    <= '0;
                        end else begin
                            ph_q <= ph_q + PH_W'(1);
                        end
                    end
                    ST_SHIFT: begin
                        if (sck_lead) begin
                            if (CPHA == CPHA_SAMPLE_LEAD) begin
                                rx_q <= {rx_q[DATA_W-2:0], miso_i};
                            end else begin
                                mosi_q <= tx_q[DATA_W-1];
                                tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                            end
                        end
                        if (sck_trail) begin
                            if (CPHA == CPHA_SAMPLE_LEAD) begin
                                mosi_q <= tx_q[DATA_W-1];
                                tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                            end else begin
                                rx_q <= {rx_q[DATA_W-2:0], miso_i};
                            end
                            if (bit_q == BIT_W'(DATA_W - 1)) begin
                                state_q <= ST_TRAIL;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end
                    end
                    ST_TRAIL: begin
                        if (ph_q == PH_W'(CLK_DIV - 1)) begin
                            state_q     <= ST_GAP;
                            ph_q        <= '0;
                            csbar_q     <= '1;
                            mosi_q      <= 1'b0;
                            fin_q       <= 1'b1;
                            data_miso_q <= rx_q;
                        end else begin
                            ph_q <= ph_q + PH_W'(1);
                        end
                    end
                    ST_GAP: begin
                        if (gap_done) begin
                            state_q <= ST_IDLE;
                            ph_q    <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            ph_q <= ph_q + PH_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign mosi_o      = mosi_q;
    assign csbar_o     = csbar_q;
    assign busy_o      = busy_q;
    assign fin_o       = fin_q;
    assign data_miso_o = data_miso_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench: a mode-0 master in MOSI->MISO loopback plus a mode-3,
// three-slave master with MISO tied high or looped back.
module tb_spi_master_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        start0 = 1'b0;
    logic [0:0]  cs_sel0 = '0;
    logic [15:0] data0 = '0;
    logic        mosi0, sck0, busy0, fin0;
    logic [1:0]  csbar0;
    logic [15:0] data_miso0;

    logic        start1 = 1'b0;
    logic [1:0]  cs_sel1 = '0;
    logic [15:0] data1 = '0;
    logic        loop1 = 1'b0;
    logic        miso1;
    logic        mosi1, sck1, busy1, fin1;
    logic [2:0]  csbar1;
    logic [15:0] data_miso1;

    int tests  = 0;
    int failed = 0;

    int fin0_cnt   = 0;
    int fin1_cnt   = 0;
    int sck0_rise  = 0;
    int sck1_fall  = 0;
    int mosi1_hi   = 0;

    always #5 clk = ~clk;

    assign miso1 = loop1 ? mosi1 : 1'b1;

    spi_master_param #(
        .DATA_W(16), .CLK_DIV(4), .NUM_CS(2), .CPOL(1'b0), .CPHA(1'b0), .CS_GAP(2)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .cs_sel_i(cs_sel0),
        .data_mosi_i(data0), .miso_i(mosi0), .mosi_o(mosi0), .sck_o(sck0),
        .csbar_o(csbar0), .busy_o(busy0), .fin_o(fin0), .data_miso_o(data_miso0)
    );

    spi_master_param #(
        .DATA_W(16), .CLK_DIV(2), .NUM_CS(3), .CPOL(1'b1), .CPHA(1'b1), .CS_GAP(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .cs_sel_i(cs_sel1),
        .data_mosi_i(data1), .miso_i(miso1), .mosi_o(mosi1), .sck_o(sck1),
        .csbar_o(csbar1), .busy_o(busy1), .fin_o(fin1), .data_miso_o(data_miso1)
    );

    always @(negedge clk) begin
        if (fin0 === 1'b1) fin0_cnt <= fin0_cnt + 1;
        if (fin1 === 1'b1) fin1_cnt <= fin1_cnt + 1;
        if (mosi1 === 1'b1) mosi1_hi <= mosi1_hi + 1;
    end

    always @(posedge sck0) sck0_rise <= sck0_rise + 1;
    always @(negedge sck1) sck1_fall <= sck1_fall + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Ticks until the selected master's FIN is seen high; n is the edge count.
    task automatic wait_fin(input bit which, output int n);
        n = 0;
        while (n < 400) begin
            tick();
            n++;
            if ((which ? fin1 : fin0) === 1'b1) break;
        end
    endtask

    initial begin
        int n;
        int s;
        int m;
        int f;

        #2 rst = 1'b1;
        #1;
        check("rst_csbar0", 32'(csbar0), 32'h3);
        check("rst_sck0", 32'(sck0), 32'h0);
        check("rst_mosi0", 32'(mosi0), 32'h0);
        check("rst_busy0", 32'(busy0), 32'h0);
        check("rst_fin0", 32'(fin0), 32'h0);
        check("rst_dmiso0", 32'(data_miso0), 32'h0);
        check("rst_csbar1", 32'(csbar1), 32'h7);
        check("rst_sck1", 32'(sck1), 32'h1);
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) tick();

        // Mode 0 loopback of 0xA5C3
        data0 = 16'hA5C3; cs_sel0 = 1'b0; start0 = 1'b1;
        s = sck0_rise;
        tick();
        start0 = 1'b0;
        check("acc_busy0", 32'(busy0), 32'h1);
        check("acc_csbar0", 32'(csbar0), 32'h2);
        check("lead_mosi_msb", 32'(mosi0), 32'h1);
        check("lead_sck0", 32'(sck0), 32'h0);
        wait_fin(1'b0, n);
        check("fin_latency", 32'(n), 32'd136);
        check("loop_a5c3", 32'(data_miso0), 32'hA5C3);
        check("sck_rises", 32'(sck0_rise - s), 32'd16);
        check("gap_csbar0", 32'(csbar0), 32'h3);
        check("gap_mosi0", 32'(mosi0), 32'h0);
        check("gap_busy0", 32'(busy0), 32'h1);
        tick();
        check("fin_pulse_1cyc", 32'(fin0), 32'h0);
        check("gap_busy0_b", 32'(busy0), 32'h1);
        tick();
        check("busy_fall", 32'(busy0), 32'h0);
        $display("[TB] xfer dut0 sent 0xa5c3 got 0x%04h latency %0d", data_miso0, n);

        // CS_SEL=1 and START re-pulsed while busy
        cs_sel0 = 1'b1; data0 = 16'h5A0F; start0 = 1'b1;
        f = fin0_cnt;
        tick();
        start0 = 1'b0;
        check("cs1_csbar", 32'(csbar0), 32'h1);
        repeat (10) tick();
        cs_sel0 = 1'b0; data0 = 16'hFFFF; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("busy_restart_csbar", 32'(csbar0), 32'h1);
        wait_fin(1'b0, n);
        check("busy_restart_latency", 32'(n), 32'd125);
        check("busy_restart_data", 32'(data_miso0), 32'h5A0F);
        repeat (5) tick();
        check("one_fin", 32'(fin0_cnt - f), 32'd1);
        check("idle_after_cs1", 32'(busy0), 32'h0);
        $display("[TB] xfer dut0 cs1 sent 0x5a0f got 0x%04h", data_miso0);

        // Out-of-range chip select on the three-slave master
        cs_sel1 = 2'd3; data1 = 16'h1234; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("bad_sel_busy", 32'(busy1), 32'h0);
        check("bad_sel_csbar", 32'(csbar1), 32'h7);
        repeat (3) tick();
        check("bad_sel_still_idle", 32'(busy1), 32'h0);
        $display("[TB] xfer dut1 cs3 dropped busy=%0d", busy1);

        // Mode 3, MISO tied high, send zero
        loop1 = 1'b0; data1 = 16'h0000; cs_sel1 = 2'd2; start1 = 1'b1;
        s = sck1_fall; m = mosi1_hi;
        tick();
        start1 = 1'b0;
        check("m3_csbar", 32'(csbar1), 32'h3);
        check("m3_sck_idle", 32'(sck1), 32'h1);
        check("m3_busy", 32'(busy1), 32'h1);
        wait_fin(1'b1, n);
        check("m3_latency", 32'(n), 32'd68);
        check("m3_ones", 32'(data_miso1), 32'hFFFF);
        check("m3_lead_edges", 32'(sck1_fall - s), 32'd16);
        check("m3_mosi_low", 32'(mosi1_hi - m), 32'd0);
        check("m3_sck_rest", 32'(sck1), 32'h1);
        $display("[TB] xfer dut1 sent 0x0000 got 0x%04h", data_miso1);
        repeat (2) tick();

        // Mode 3 loopback
        loop1 = 1'b1; data1 = 16'hC35A; cs_sel1 = 2'd0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("m3_lead_mosi0", 32'(mosi1), 32'h0);
        check("m3_csbar0", 32'(csbar1), 32'h6);
        wait_fin(1'b1, n);
        check("m3_loop_latency", 32'(n), 32'd68);
        check("m3_loop_c35a", 32'(data_miso1), 32'hC35A);
        $display("[TB] xfer dut1 sent 0xc35a got 0x%04h", data_miso1);
        repeat (2) tick();

        // START held: back-to-back words, data/CS changed mid-transfer
        data0 = 16'h0F0F; cs_sel0 = 1'b0; start0 = 1'b1;
        f = fin0_cnt;
        tick();
        wait_fin(1'b0, n);
        check("b2b_first_latency", 32'(n), 32'd136);
        check("b2b_first_data", 32'(data_miso0), 32'h0F0F);
        check("b2b_gap0_csbar", 32'(csbar0), 32'h3);
        tick();
        check("b2b_gap1_csbar", 32'(csbar0), 32'h3);
        check("b2b_gap1_busy", 32'(busy0), 32'h1);
        tick();
        check("b2b_restart_csbar", 32'(csbar0), 32'h2);
        check("b2b_restart_busy", 32'(busy0), 32'h1);
        start0 = 1'b0; data0 = 16'hFFFF; cs_sel0 = 1'b1;
        tick();
        check("b2b_cs_hold", 32'(csbar0), 32'h2);
        wait_fin(1'b0, n);
        check("b2b_second_latency", 32'(n), 32'd135);
        check("b2b_second_data", 32'(data_miso0), 32'h0F0F);
        repeat (3) tick();
        check("b2b_two_fins", 32'(fin0_cnt - f), 32'd2);
        check("b2b_idle", 32'(busy0), 32'h0);
        $display("[TB] xfer dut0 back-to-back 0x0f0f x2 got 0x%04h", data_miso0);

        // Reset mid-transfer, then a clean transfer
        data0 = 16'hA5C3; cs_sel0 = 1'b0; start0 = 1'b1;
        f = fin0_cnt;
        tick();
        start0 = 1'b0;
        repeat (65) tick();
        check("mid_sck_high", 32'(sck0), 32'h1);
        check("mid_busy", 32'(busy0), 32'h1);
        rst = 1'b1;
        #1;
        check("abort_csbar", 32'(csbar0), 32'h3);
        check("abort_sck", 32'(sck0), 32'h0);
        check("abort_busy", 32'(busy0), 32'h0);
        check("abort_mosi", 32'(mosi0), 32'h0);
        check("abort_fin", 32'(fin0), 32'h0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (150) tick();
        check("abort_no_fin", 32'(fin0_cnt - f), 32'd0);
        check("abort_dmiso", 32'(data_miso0), 32'h0);
        data0 = 16'h1234; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_fin(1'b0, n);
        check("post_rst_latency", 32'(n), 32'd136);
        check("post_rst_1234", 32'(data_miso0), 32'h1234);
        $display("[TB] xfer dut0 after reset sent 0x1234 got 0x%04h", data_miso0);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
